// File: rtl/branch_predictor.sv
// Bimodal branch predictor: direct-mapped tagged BHT of 2-bit saturating counters,
// plus resolved-branch and mispredict statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] guess_pc,
  input  logic        guess_valid,
  output logic        guess_taken,
  input  logic [31:0] check_pc,
  input  logic        check_valid,
  input  logic        check_taken,
  input  logic        check_pred,
  input  logic        stall,
  output logic        br_pred_correct,
  input  logic        stats_clear,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] guess_idx;
  logic [IDX_W-1:0] check_idx;
  logic [TAG_W-1:0] guess_tag;
  logic [TAG_W-1:0] check_tag;
  logic             check_hit;
  logic             update;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign guess_idx      = guess_pc[IDX_W+1:2];
  assign guess_tag      = guess_pc[31:IDX_W+2];
  assign check_idx      = check_pc[IDX_W+1:2];
  assign check_tag      = check_pc[31:IDX_W+2];
  assign unused_pc_bits = ^{guess_pc[1:0], check_pc[1:0]};

  // Decode-stage lookup reads only the registered table, never the check port.
  always_comb begin
    guess_taken = 1'b0;
    if (rst && guess_valid && valid_q[guess_idx] && (tag_q[guess_idx] == guess_tag)) begin
      guess_taken = ctr_q[guess_idx][1];
    end
  end

  assign br_pred_correct = !check_valid || (check_pred == check_taken);
  assign update          = check_valid && !stall;
  assign check_hit       = valid_q[check_idx] && (tag_q[check_idx] == check_tag);

  // Saturating train on a hit; a miss reallocates the line at the weak state of the outcome.
  always_comb begin
    ctr_next = check_taken ? CTR_WT : CTR_WNT;
    if (check_hit) begin
      if (check_taken) begin
        ctr_next = (ctr_q[check_idx] == CTR_ST) ? CTR_ST : ctr_q[check_idx] + 2'd1;
      end else begin
        ctr_next = (ctr_q[check_idx] == CTR_SNT) ? CTR_SNT : ctr_q[check_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (update) begin
      valid_q[check_idx] <= 1'b1;
      tag_q[check_idx]   <= check_tag;
      ctr_q[check_idx]   <= ctr_next;
    end
  end

  // Clear wins over a same-cycle increment, and works even while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (stats_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update) begin
      branch_count     <= branch_count + 32'd1;
      mispredict_count <= mispredict_count + 32'(check_pred != check_taken);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor, checked against a
// line/tag/counter reference model of the BHT and statistics.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 32;
  localparam int unsigned IDX_W   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] guess_pc;
  logic        guess_valid;
  logic        guess_taken;
  logic [31:0] check_pc;
  logic        check_valid;
  logic        check_taken;
  logic        check_pred;
  logic        stall;
  logic        br_pred_correct;
  logic        stats_clear;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_bc;
  logic [31:0] m_mc;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk             (clk),
    .rst             (rst),
    .guess_pc        (guess_pc),
    .guess_valid     (guess_valid),
    .guess_taken     (guess_taken),
    .check_pc        (check_pc),
    .check_valid     (check_valid),
    .check_taken     (check_taken),
    .check_pred      (check_pred),
    .stall           (stall),
    .br_pred_correct (br_pred_correct),
    .stats_clear     (stats_clear),
    .branch_count    (branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic int unsigned line_of(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
    end
    m_bc = 32'd0;
    m_mc = 32'd0;
  endfunction

  function automatic logic model_guess();
    int unsigned l;
    if (!rst || !guess_valid) return 1'b0;
    l = line_of(guess_pc);
    return m_valid[l] && (m_tag[l] == tag_of(guess_pc)) && (m_ctr[l] >= 2);
  endfunction

  function automatic logic model_correct();
    return !check_valid || (check_pred == check_taken);
  endfunction

  // Applies what one rising edge should do, using the inputs stable across it.
  function automatic void model_edge();
    int unsigned l;
    bit upd;
    if (!rst) return;
    upd = check_valid && !stall;
    if (upd) begin
      l = line_of(check_pc);
      if (m_valid[l] && m_tag[l] == tag_of(check_pc)) begin
        if (check_taken) m_ctr[l] = (m_ctr[l] == 3) ? 3 : m_ctr[l] + 1;
        else             m_ctr[l] = (m_ctr[l] == 0) ? 0 : m_ctr[l] - 1;
      end else begin
        m_valid[l] = 1'b1;
        m_tag[l]   = tag_of(check_pc);
        m_ctr[l]   = check_taken ? 2 : 1;
      end
    end
    if (stats_clear) begin
      m_bc = 32'd0;
      m_mc = 32'd0;
    end else if (upd) begin
      m_bc = m_bc + 32'd1;
      if (check_pred != check_taken) m_mc = m_mc + 32'd1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    #1;
    chk({tag, "/guess"}, 32'(guess_taken), 32'(model_guess()));
    chk({tag, "/correct"}, 32'(br_pred_correct), 32'(model_correct()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk({tag, "/bcount"}, branch_count, m_bc);
    chk({tag, "/mcount"}, mispredict_count, m_mc);
  endtask

  task automatic drive_check(input logic [31:0] pc, input logic v, input logic t, input logic p);
    check_pc    = pc;
    check_valid = v;
    check_taken = t;
    check_pred  = p;
  endtask

  initial begin
    rst         = 1'b0;
    guess_pc    = 32'h100;
    guess_valid = 1'b1;
    stall       = 1'b0;
    stats_clear = 1'b0;
    drive_check(32'h100, 1'b1, 1'b1, 1'b0);
    model_reset();

    // Edges while held in reset must not train or count.
    repeat (2) @(negedge clk);
    #1;
    chk("rst/guess", 32'(guess_taken), 32'd0);
    chk("rst/correct", 32'(br_pred_correct), 32'd0);
    chk("rst/bcount", branch_count, 32'd0);
    chk("rst/mcount", mispredict_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive_check(32'h100, 1'b0, 1'b0, 1'b0);
    cycle("req33");

    drive_check(32'h100, 1'b1, 1'b1, 1'b0);
    cycle("req34");
    chk("req34/bc_is_1", branch_count, 32'd1);
    chk("req34/mc_is_1", mispredict_count, 32'd1);
    drive_check(32'h100, 1'b0, 1'b0, 1'b0);
    #1 chk("req34/guess_now_1", 32'(guess_taken), 32'd1);
    cycle("req34_post");

    for (int i = 0; i < 4; i++) begin
      drive_check(32'h100, 1'b1, 1'b1, 1'b1);
      cycle($sformatf("req35_t%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      drive_check(32'h100, 1'b1, 1'b0, 1'b1);
      cycle($sformatf("req35_n%0d", i));
    end
    drive_check(32'h100, 1'b0, 1'b0, 1'b0);
    #1 chk("req35/guess_0", 32'(guess_taken), 32'd0);
    cycle("req35_post");

    // Aliasing: 0x100 and 0x180 share line 0 with different tags.
    for (int i = 0; i < 2; i++) begin
      drive_check(32'h100, 1'b1, 1'b1, 1'b1);
      cycle($sformatf("req36_train%0d", i));
    end
    drive_check(32'h180, 1'b1, 1'b0, 1'b1);
    cycle("req36_alias");
    drive_check(32'h0, 1'b0, 1'b0, 1'b0);
    guess_pc = 32'h100;
    #1 chk("req36/guess100", 32'(guess_taken), 32'd0);
    guess_pc = 32'h180;
    #1 chk("req36/guess180", 32'(guess_taken), 32'd0);
    cycle("req36_post");

    stall = 1'b1;
    drive_check(32'h180, 1'b1, 1'b1, 1'b0);
    cycle("req37_stall");
    stall = 1'b0;
    drive_check(32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("req37/stall_no_train", 32'(guess_taken), 32'd0);
    stats_clear = 1'b1;
    drive_check(32'h180, 1'b1, 1'b1, 1'b0);
    cycle("req37_clear");
    chk("req37/bc_zero", branch_count, 32'd0);
    chk("req37/mc_zero", mispredict_count, 32'd0);
    stats_clear = 1'b0;
    drive_check(32'h180, 1'b1, 1'b1, 1'b0);
    cycle("req37_count");
    stall       = 1'b1;
    stats_clear = 1'b1;
    cycle("req37_clear_stalled");
    stall       = 1'b0;
    stats_clear = 1'b0;

    // Same-cycle guess and check: prediction uses the pre-update line.
    guess_pc = 32'h300;
    drive_check(32'h300, 1'b1, 1'b1, 1'b0);
    cycle("req24_same");
    drive_check(32'h0, 1'b0, 1'b0, 1'b0);
    cycle("req24_next");

    force dut.branch_count     = 32'hFFFF_FFFF;
    force dut.mispredict_count = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count;
    release dut.mispredict_count;
    m_bc = 32'hFFFF_FFFF;
    m_mc = 32'hFFFF_FFFF;
    drive_check(32'h104, 1'b1, 1'b1, 1'b0);
    cycle("req38_wrap");
    chk("req38/bc_wrapped", branch_count, 32'd0);

    guess_pc = 32'h180;
    drive_check(32'h180, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("req38_rst/guess", 32'(guess_taken), 32'd0);
    chk("req38_rst/correct", 32'(br_pred_correct), 32'(model_correct()));
    chk("req38_rst/bcount", branch_count, 32'd0);
    chk("req38_rst/mcount", mispredict_count, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("req38_rst/first_update", branch_count, m_bc);
    drive_check(32'h0, 1'b0, 1'b0, 1'b0);
    cycle("req38_rst_post");

    for (int n = 0; n < 400; n++) begin
      check_pc    = 32'h1000 | 32'($urandom_range(0, 3) << 7) | 32'($urandom_range(0, 7) << 2);
      check_valid = ($urandom_range(0, 3) != 0);
      check_taken = 1'($urandom_range(0, 1));
      check_pred  = 1'($urandom_range(0, 1));
      guess_pc    = ($urandom_range(0, 1) != 0) ? check_pc
                  : 32'h1000 | 32'($urandom_range(0, 3) << 7) | 32'($urandom_range(0, 7) << 2);
      guess_valid = ($urandom_range(0, 4) != 0);
      stall       = ($urandom_range(0, 4) == 0);
      stats_clear = ($urandom_range(0, 19) == 0);
      cycle($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
